data_ram: RTL and testbench
===========================

// Module: data_ram
// PURPOSE
//  Data-memory responder for the execute stage's RAM port: performs byte-lane stores and returns
//  combinational load data. After reset, a clear engine zeroes the array one word per cycle,
//  then raises ready. Illegal byte-select patterns are detected and reported through a sticky error.
//  Sits beside the core top-level, with its inputs driven directly by the execute stage's ram_* outputs.
// PARAMETERS
//  DEPTH_LOG2      12  log2 of word count (4096 words = 16 KiB)
//  CLEAR_ON_RESET  1   1: zero the whole array after reset; 0: skip clear, ready one cycle after reset release
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   reset, synchronous, active-low (`RstEnable = 1'b0)
//  ram_we        in   1   store strobe (`WriteEnable)
//  ram_sel       in   4   byte-lane select, bit n = byte [8n+7:8n]
//  ram_wraddr    in   32  byte address for both load and store
//  ram_wdata     in   32  store data, already lane-replicated by the driver
//  ram_rdata     out  32  load data, full word at the addressed word
//  ready         out  1   array usable (clear finished)
//  misalign_err  out  1   sticky: an illegal store select was seen
//  err_addr      out  32  ram_wraddr of the first illegal store
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-low. All state below changes only on posedge clk.
//  Reset values, while rst==0: state=CLEAR (or READY_WAIT if CLEAR_ON_RESET=0), clr_cnt=0,
//   ready=0, misalign_err=0, err_addr=0, ram_rdata=0. No array writes occur during reset.
//  Addressing: word index = ram_wraddr[DEPTH_LOG2+1:2]. Upper bits are ignored, so addresses alias
//   modulo 4*2^DEPTH_LOG2. Bits [1:0] are used only through ram_sel.
//  Read path: ram_rdata = mem[idx] combinationally when ready=1, else 0.
//   Zero-cycle latency, because the execute stage consumes data in the same cycle.
//  Store: on posedge when ready & ram_we & legal(ram_sel), byte n of mem[idx] <= ram_wdata[8n+7:8n]
//   for each set bit n. Unselected bytes are unchanged.
//   legal(sel) = sel in {0001,0010,0100,1000,0011,1100,1111}.
//  Illegal store: ready & ram_we & !legal(ram_sel), including sel=0000. No array write.
//   misalign_err<=1. err_addr<=ram_wraddr only if misalign_err was 0 (first error kept).
//  ram_we=0: no write and no error check, whatever ram_sel is (loads drive sel=0000).
//  Read during write, same cycle and same word: ram_rdata shows pre-write data. New data is visible from the next cycle.
//  FSM:
//   CLEAR: each cycle writes mem[clr_cnt]=0 and increments clr_cnt.
//    When clr_cnt==2^DEPTH_LOG2-1 is written: state<=READY, ready<=1.
//    ready therefore rises after exactly 2^DEPTH_LOG2 edges following reset release.
//   READY_WAIT (CLEAR_ON_RESET=0): one cycle, then READY with ready=1. Array contents are left undefined.
//   READY: normal operation; this is the terminal state until reset.
//  During CLEAR or READY_WAIT, ram_we is ignored: no write and no error.
//  Reset mid-clear: clr_cnt returns to 0 and the clear restarts from word 0 after release.
//  clr_cnt width is DEPTH_LOG2. Its terminal compare must not rely on wrap-around.
// STRUCTURE
//  defines.v gains:
//   - `SelByte0..3, `SelHalf0, `SelHalf1, `SelWord
//   - `RamDepthLog2 default
//   - `RamStClear, `RamStWait, `RamStReady (2-bit state codes)
//  Existing `MemBus, `MemAddrBus, `MenSelBus, `MenSelNop, `WriteEnable and `RstEnable are reused.
//  Sub-module ram_byte_lane (x4): 8-bit x 2^DEPTH_LOG2 array with a write enable, combinational read and clear-write port.
//  data_ram holds the FSM, the legality decode and the error capture.
// TESTING  (DEPTH_LOG2=4 for the sim build)
//  1 Reset release, then poll ready -> ready=0 for 16 edges, 1 on the 16th. Reading every word returns 0x00000000.
//  2 SW 0xDEADBEEF @0x8, then load @0x8 -> 0xDEADBEEF.
//    SB sel=0010 data=0x55555555 @0x9 -> 0xDEAD55EF.
//  3 SH sel=1100 data=0x12341234 @0xA -> word 0x123455EF.
//    Write @0x48 (aliases 0x8) -> visible at 0x8.
//  4 Store sel=0101 @0x20, then sel=0000 @0x30 -> no writes, misalign_err=1, err_addr=0x20 kept.
//    Loads with sel=0000 before these stores raise no error.
//  5 Same-cycle store 0xAAAAAAAA and read @0x4 -> rdata shows old value this cycle, 0xAAAAAAAA next cycle.
//  6 Assert rst at clr_cnt=7, release -> clear restarts, ready after 16 more edges.
//    A ram_we pulse during clear is dropped and misalign_err stays 0.

Source files
------------

// File: rtl/data_ram_pkg.sv
// Shared constants, byte-select codes and FSM state type for the data RAM responder.
// Imported by data_ram and its byte-lane sub-module.
package data_ram_pkg;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;

    localparam int RAM_DEPTH_LOG2 = 12;
    localparam int MEM_BUS_W      = 32;
    localparam int MEM_ADDR_W     = 32;
    localparam int MEM_SEL_W      = 4;
    localparam int BYTE_W         = 8;

    localparam logic [MEM_SEL_W-1:0] SEL_NOP   = 4'b0000;
    localparam logic [MEM_SEL_W-1:0] SEL_BYTE0 = 4'b0001;
    localparam logic [MEM_SEL_W-1:0] SEL_BYTE1 = 4'b0010;
    localparam logic [MEM_SEL_W-1:0] SEL_BYTE2 = 4'b0100;
    localparam logic [MEM_SEL_W-1:0] SEL_BYTE3 = 4'b1000;
    localparam logic [MEM_SEL_W-1:0] SEL_HALF0 = 4'b0011;
    localparam logic [MEM_SEL_W-1:0] SEL_HALF1 = 4'b1100;
    localparam logic [MEM_SEL_W-1:0] SEL_WORD  = 4'b1111;

    typedef enum logic [1:0] {
        RAM_ST_CLEAR = 2'b00,
        RAM_ST_WAIT  = 2'b01,
        RAM_ST_READY = 2'b10
    } ram_state_t;

    // Only naturally aligned byte, halfword and word lane patterns may store.
    function automatic logic sel_is_legal(input logic [MEM_SEL_W-1:0] sel);
        logic legal;
        case (sel)
            SEL_BYTE0, SEL_BYTE1, SEL_BYTE2, SEL_BYTE3,
            SEL_HALF0, SEL_HALF1, SEL_WORD: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/data_ram_byte_lane.sv
// One 8-bit slice of the data RAM: store port, clear port and asynchronous read.
// The clear port wins over the store port; the controller never asserts both at once.
module ram_byte_lane
    import data_ram_pkg::*;
#(
    parameter int DEPTH_LOG2 = RAM_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [BYTE_W-1:0]     i_wdata,
    input  logic                  i_clr_we,
    input  logic [DEPTH_LOG2-1:0] i_clr_addr,
    output logic [BYTE_W-1:0]     o_rdata
);

    logic [BYTE_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (i_clr_we) begin
            r_mem[i_clr_addr] <= '0;
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_ram.sv
// Data-memory responder for the execute stage: byte-lane stores, zero-latency loads,
// post-reset clear engine and sticky capture of the first illegal store select.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int DEPTH_LOG2     = RAM_DEPTH_LOG2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_we,
    input  logic [MEM_SEL_W-1:0]  ram_sel,
    input  logic [MEM_ADDR_W-1:0] ram_wraddr,
    input  logic [MEM_BUS_W-1:0]  ram_wdata,
    output logic [MEM_BUS_W-1:0]  ram_rdata,
    output logic                  ready,
    output logic                  misalign_err,
    output logic [MEM_ADDR_W-1:0] err_addr
);

    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

    ram_state_t              r_state;
    ram_state_t              w_next_state;
    logic [DEPTH_LOG2-1:0]   r_clr_cnt;
    logic [DEPTH_LOG2-1:0]   w_next_cnt;
    logic                    w_clr_we;
    logic                    w_set_ready;
    logic                    r_ready;
    logic                    r_err;
    logic [MEM_ADDR_W-1:0]   r_err_addr;

    logic                    w_in_reset;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_sel_legal;
    logic                    w_store_ok;
    logic                    w_store_bad;
    logic [BYTE_W-1:0]       w_lane_rdata [MEM_SEL_W];
    logic                    w_unused_addr;

    assign w_in_reset  = (rst == RST_ENABLE);
    assign w_idx       = ram_wraddr[DEPTH_LOG2+1:2];
    assign w_sel_legal = sel_is_legal(ram_sel);

    // Upper address bits alias away and the low two bits only matter through ram_sel.
    assign w_unused_addr = ^{ram_wraddr[MEM_ADDR_W-1:DEPTH_LOG2+2], ram_wraddr[1:0]};

    assign w_store_ok  = !w_in_reset && r_ready && (ram_we == WRITE_ENABLE) && w_sel_legal;
    assign w_store_bad = r_ready && (ram_we == WRITE_ENABLE) && !w_sel_legal;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_clr_cnt;
        w_clr_we     = 1'b0;
        w_set_ready  = 1'b0;
        case (r_state)
            RAM_ST_CLEAR: begin
                w_clr_we = !w_in_reset;
                // Stop on an explicit compare so the counter never has to wrap to finish.
                if (r_clr_cnt == LAST_IDX) begin
                    w_next_state = RAM_ST_READY;
                    w_set_ready  = 1'b1;
                end else begin
                    w_next_cnt = r_clr_cnt + 1'b1;
                end
            end
            RAM_ST_WAIT: begin
                w_next_state = RAM_ST_READY;
                w_set_ready  = 1'b1;
            end
            RAM_ST_READY: begin
                w_next_state = RAM_ST_READY;
            end
            default: begin
                w_next_state = RAM_ST_READY;
                w_set_ready  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_in_reset) begin
            if (CLEAR_ON_RESET) begin
                r_state <= RAM_ST_CLEAR;
            end else begin
                r_state <= RAM_ST_WAIT;
            end
            r_clr_cnt  <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_state   <= w_next_state;
            r_clr_cnt <= w_next_cnt;
            if (w_set_ready) begin
                r_ready <= 1'b1;
            end
            // Only the first offending address is kept; the flag itself stays sticky.
            if (w_store_bad) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_addr <= ram_wraddr;
                end
            end
        end
    end

    for (genvar g_lane = 0; g_lane < MEM_SEL_W; g_lane++) begin : g_lanes
        ram_byte_lane #(
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_lane (
            .clk        (clk),
            .i_we       (w_store_ok & ram_sel[g_lane]),
            .i_addr     (w_idx),
            .i_wdata    (ram_wdata[BYTE_W*g_lane +: BYTE_W]),
            .i_clr_we   (w_clr_we),
            .i_clr_addr (r_clr_cnt),
            .o_rdata    (w_lane_rdata[g_lane])
        );
    end

    assign ram_rdata    = r_ready ? {w_lane_rdata[3], w_lane_rdata[2], w_lane_rdata[1], w_lane_rdata[0]}
                                  : '0;
    assign ready        = r_ready;
    assign misalign_err = r_err;
    assign err_addr     = r_err_addr;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram (16-word build) against a word-array reference model.
// Scenario tasks run in sequence; random loads/stores are checked against the model.
module tb_data_ram;

    logic        clk;
    logic        rst;
    logic        ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wraddr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ready;
    logic        misalign_err;
    logic [31:0] err_addr;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_mem [16];
    logic        m_err;
    logic [31:0] m_err_addr;

    data_ram #(
        .DEPTH_LOG2     (4),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ram_we       (ram_we),
        .ram_sel      (ram_sel),
        .ram_wraddr   (ram_wraddr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .ready        (ready),
        .misalign_err (misalign_err),
        .err_addr     (err_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit model_legal(input logic [3:0] sel);
        return ($countones(sel) == 1) || (sel == 4'b0011) || (sel == 4'b1100) || (sel == 4'b1111);
    endfunction

    task automatic model_clear();
        for (int w = 0; w < 16; w++) m_mem[w] = 32'h0;
        m_err      = 1'b0;
        m_err_addr = 32'h0;
    endtask

    // Applies one accepted store edge to the model: byte merge or error capture.
    task automatic model_store(input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] data);
        int idx;
        idx = (addr / 4) % 16;
        if (model_legal(sel)) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) m_mem[idx][8*b +: 8] = data[8*b +: 8];
        end else begin
            if (!m_err) m_err_addr = addr;
            m_err = 1'b1;
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] data);
        ram_we     = we;
        ram_sel    = sel;
        ram_wraddr = addr;
        ram_wdata  = data;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        drive(1'b1, sel, addr, data);
        @(posedge clk);
        #1;
        model_store(sel, addr, data);
        drive(1'b0, 4'b0000, addr, 32'h0);
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0;
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", misalign_err); end
        checks++; if (err_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_err_addr: got %h expected 00000000", err_addr); end
        checks++; if (ram_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", ram_rdata); end
        rst = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != 16) begin errors++; $display("[TB] FAIL clear_latency: ready after %0d edges expected 16", n); end
        model_clear();
        for (int w = 0; w < 16; w++) begin
            drive(1'b0, 4'b0000, w * 4 + $urandom_range(0, 3), 32'h0);
            #1;
            checks++; if (ram_rdata !== m_mem[w]) begin errors++; $display("[TB] FAIL cleared_word%0d: got %h expected %h", w, ram_rdata, m_mem[w]); end
        end
    endtask

    task automatic test_word_store();
        do_store(32'h8, 32'hDEADBEEF, 4'b1111);
        #1;
        checks++; if (ram_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sw_load: got %h expected deadbeef", ram_rdata); end
        do_store(32'h9, 32'h55555555, 4'b0010);
        #1;
        checks++; if (ram_rdata !== 32'hDEAD55EF) begin errors++; $display("[TB] FAIL sb_merge: got %h expected dead55ef", ram_rdata); end
    endtask

    task automatic test_half_alias();
        do_store(32'hA, 32'h12341234, 4'b1100);
        drive(1'b0, 4'b0000, 32'h8, 32'h0);
        #1;
        checks++; if (ram_rdata !== 32'h123455EF) begin errors++; $display("[TB] FAIL sh_merge: got %h expected 123455ef", ram_rdata); end
        do_store(32'h48, 32'hCAFEF00D, 4'b1111);
        drive(1'b0, 4'b0000, 32'h8, 32'h0);
        #1;
        checks++; if (ram_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL alias_store: got %h expected cafef00d", ram_rdata); end
    endtask

    task automatic test_rdw();
        logic [31:0] old_val;
        old_val = m_mem[1];
        drive(1'b1, 4'b1111, 32'h4, 32'hAAAAAAAA);
        #1;
        checks++; if (ram_rdata !== old_val) begin errors++; $display("[TB] FAIL rdw_old: got %h expected %h", ram_rdata, old_val); end
        @(posedge clk);
        #1;
        model_store(4'b1111, 32'h4, 32'hAAAAAAAA);
        drive(1'b0, 4'b0000, 32'h4, 32'h0);
        #1;
        checks++; if (ram_rdata !== 32'hAAAAAAAA) begin errors++; $display("[TB] FAIL rdw_new: got %h expected aaaaaaaa", ram_rdata); end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0000, 32'h20 + 4 * i, 32'hFFFFFFFF);
            @(posedge clk);
            #1;
        end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL load_no_err: got %b expected 0", misalign_err); end
        do_store(32'h20, 32'hFFFFFFFF, 4'b0101);
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag: got %b expected 1", misalign_err); end
        checks++; if (err_addr !== 32'h20) begin errors++; $display("[TB] FAIL illegal_addr: got %h expected 00000020", err_addr); end
        drive(1'b0, 4'b0000, 32'h20, 32'h0);
        #1;
        checks++; if (ram_rdata !== 32'h0) begin errors++; $display("[TB] FAIL illegal_nowrite: got %h expected 00000000", ram_rdata); end
        do_store(32'h30, 32'hFFFFFFFF, 4'b0000);
        checks++; if (err_addr !== 32'h20) begin errors++; $display("[TB] FAIL first_err_kept: got %h expected 00000020", err_addr); end
        drive(1'b0, 4'b0000, 32'h30, 32'h0);
        #1;
        checks++; if (ram_rdata !== 32'h0) begin errors++; $display("[TB] FAIL zero_sel_nowrite: got %h expected 00000000", ram_rdata); end
    endtask

    task automatic test_random();
        logic [3:0]  sel_pool [13] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h5, 4'h6, 4'h0, 4'h9, 4'h7, 4'hE};
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          idx;
        for (int i = 0; i < 80; i++) begin
            addr = $urandom_range(0, 255);
            data = $urandom;
            sel  = sel_pool[$urandom_range(0, 12)];
            if ($urandom_range(0, 2) == 0) begin
                idx = (addr / 4) % 16;
                drive(1'b0, 4'b0000, addr, data);
                #1;
                checks++; if (ram_rdata !== m_mem[idx]) begin errors++; $display("[TB] FAIL rand_load @%h: got %h expected %h", addr, ram_rdata, m_mem[idx]); end
                @(posedge clk);
                #1;
            end else begin
                do_store(addr, data, sel);
                checks++; if (misalign_err !== m_err || err_addr !== m_err_addr) begin
                    errors++;
                    $display("[TB] FAIL rand_err sel=%b: got %b/%h expected %b/%h", sel, misalign_err, err_addr, m_err, m_err_addr);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        rst = 1'b0;
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL midclr_ready: got %b expected 0", ready); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL midclr_err_cleared: got %b expected 0", misalign_err); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            if (n == 2)      drive(1'b1, 4'b1111, 32'h0, 32'h12345678);
            else if (n == 3) drive(1'b1, 4'b0101, 32'h4, 32'hFFFFFFFF);
            else             drive(1'b0, 4'b0000, 32'h0, 32'h0);
            @(posedge clk);
            #1;
            n++;
        end
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        checks++; if (n != 16) begin errors++; $display("[TB] FAIL restart_latency: ready after %0d edges expected 16", n); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL clear_we_err: got %b expected 0", misalign_err); end
        model_clear();
        for (int w = 0; w < 16; w++) begin
            drive(1'b0, 4'b0000, w * 4, 32'h0);
            #1;
            checks++; if (ram_rdata !== m_mem[w]) begin errors++; $display("[TB] FAIL restart_word%0d: got %h expected %h", w, ram_rdata, m_mem[w]); end
        end
    endtask

    initial begin
        $display("[TB] data_ram bench start");
        test_reset();
        test_word_store();
        test_half_alias();
        test_rdw();
        test_illegal();
        test_random();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
